// File: rtl/receptor_serial_pkg.sv
// Shared types and constants for the receptor_serial framed receiver.
package receptor_serial_pkg;

  // Receiver FSM encoding.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StData = 2'b01,
    StStop = 2'b10
  } rx_state_e;

  // Bit-order selector values for DIR.
  localparam logic MsbFirst = 1'b0;
  localparam logic LsbFirst = 1'b1;

endpackage

// File: rtl/receptor_serial_if.sv
// Serial-line plus parallel-handshake bundle for receptor_serial.
// slave is the receiver side; master is the line driver / word consumer.
interface receptor_serial_if #(
  parameter int unsigned WIDTH = 4
);
  logic             ENB;
  logic             DIR;
  logic             S_IN;
  logic             READY;
  logic [WIDTH-1:0] Q;
  logic             VALID;
  logic             FRAME_ERR;
  logic             OVERRUN;
  logic             BUSY;

  modport master (
    output ENB, DIR, S_IN, READY,
    input  Q, VALID, FRAME_ERR, OVERRUN, BUSY
  );

  modport slave (
    input  ENB, DIR, S_IN, READY,
    output Q, VALID, FRAME_ERR, OVERRUN, BUSY
  );
endinterface

// File: rtl/receptor_retencion.sv
// Output holding register: keeps the last good word with a VALID/READY
// handshake and flags a dropped word when a delivery finds it still full.
module receptor_retencion #(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             deliver_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] q_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [WIDTH-1:0] q_q;
  logic             valid_q;
  logic             overrun_q;

  // Load on delivery when empty or being drained this cycle; otherwise drop and pulse overrun.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q       <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (deliver_i) begin
        if (!valid_q || ready_i) begin
          q_q     <= data_i;
          valid_q <= 1'b1;
        end else begin
          overrun_q <= 1'b1;
        end
      end else if (valid_q && ready_i) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign q_o       = q_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/receptor_serial.sv
// Framed serial-to-parallel receiver: start bit, WIDTH data bits in either
// order, stop bit; good words go to the holding register one cycle later.
module receptor_serial
  import receptor_serial_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic              clk,
  input  logic              RESET_N,
  receptor_serial_if.slave  bus
);

  localparam int unsigned     CntW    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  rx_state_e        state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sh_q;
  logic             dir_q;
  logic             frame_err_q;
  logic             deliver_q;

  // Receive FSM; advances only on strobes, pulses are cleared every cycle.
  always_ff @(posedge clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      sh_q        <= '0;
      dir_q       <= MsbFirst;
      frame_err_q <= 1'b0;
      deliver_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      deliver_q   <= 1'b0;
      if (bus.ENB) begin
        unique case (state_q)
          StIdle: begin
            if (!bus.S_IN) begin
              state_q <= StData;
              cnt_q   <= '0;
              dir_q   <= bus.DIR;
            end
          end
          StData: begin
            if (dir_q == LsbFirst) begin
              sh_q <= {bus.S_IN, sh_q[WIDTH-1:1]};
            end else begin
              sh_q <= {sh_q[WIDTH-2:0], bus.S_IN};
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == CntLast) begin
              state_q <= StStop;
            end
          end
          StStop: begin
            // A low stop bit is an error only; it never doubles as a start bit.
            state_q <= StIdle;
            if (bus.S_IN) begin
              deliver_q <= 1'b1;
            end else begin
              frame_err_q <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // sh_q cannot change before the delivery edge: a back-to-back start bit
  // only moves IDLE->DATA without shifting.
  receptor_retencion #(
    .WIDTH (WIDTH)
  ) u_retencion (
    .clk_i     (clk),
    .rst_ni    (RESET_N),
    .deliver_i (deliver_q),
    .data_i    (sh_q),
    .ready_i   (bus.READY),
    .q_o       (bus.Q),
    .valid_o   (bus.VALID),
    .overrun_o (bus.OVERRUN)
  );

  assign bus.FRAME_ERR = frame_err_q;
  assign bus.BUSY      = (state_q != StIdle);

endmodule

// File: tb/tb_receptor_serial.sv
// Directed bench for receptor_serial (WIDTH=4).
module tb_receptor_serial;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  receptor_serial_if #(.WIDTH(4)) bus ();

  receptor_serial #(
    .WIDTH (4)
  ) dut (
    .clk     (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    bus.ENB  = 1'b1;
    bus.S_IN = b;
    tick();
  endtask

  // Start, four data bits, stop, sent left to right.
  task automatic send_seq(input logic [5:0] seq);
    for (int i = 5; i >= 0; i--) send_bit(seq[i]);
  endtask

  // Two ENB=0 cycles with the line glitched low, then one strobe.
  task automatic send_slow(input logic b);
    bus.ENB  = 1'b0;
    bus.S_IN = 1'b0;
    tick();
    tick();
    bus.ENB  = 1'b1;
    bus.S_IN = b;
    tick();
  endtask

  task automatic consume();
    bus.READY = 1'b1;
    tick();
    bus.READY = 1'b0;
  endtask

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst_n     = 1'b0;
    bus.ENB   = 1'b1;
    bus.DIR   = 1'b0;
    bus.S_IN  = 1'b1;
    bus.READY = 1'b0;
    tick();
    tick();
    check_eq("rst_q", bus.Q, 0);
    check_eq("rst_valid", bus.VALID, 0);
    check_eq("rst_ferr", bus.FRAME_ERR, 0);
    check_eq("rst_ovr", bus.OVERRUN, 0);
    check_eq("rst_busy", bus.BUSY, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // 1: MSB first 1011, held until READY.
    bus.DIR = 1'b0;
    send_bit(1'b0);
    check_eq("t1_busy_start", bus.BUSY, 1);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("t1_busy_after_stop", bus.BUSY, 0);
    check_eq("t1_valid_not_yet", bus.VALID, 0);
    check_eq("t1_ferr", bus.FRAME_ERR, 0);
    send_bit(1'b1);
    check_eq("t1_valid", bus.VALID, 1);
    check_eq("t1_q", bus.Q, 4'b1011);
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("t1_q_hold", bus.Q, 4'b1011);
    check_eq("t1_valid_hold", bus.VALID, 1);
    consume();
    check_eq("t1_valid_drop", bus.VALID, 0);

    // 2: LSB first, DIR flipped mid-frame has no effect.
    bus.DIR = 1'b1;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    bus.DIR = 1'b0;
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("t2_valid", bus.VALID, 1);
    check_eq("t2_q_lsb", bus.Q, 4'b1101);
    consume();

    // 3: low stop bit.
    send_seq(6'b011110);
    check_eq("t3_ferr", bus.FRAME_ERR, 1);
    check_eq("t3_busy", bus.BUSY, 0);
    send_bit(1'b1);
    check_eq("t3_ferr_pulse", bus.FRAME_ERR, 0);
    check_eq("t3_no_restart", bus.BUSY, 0);
    check_eq("t3_valid", bus.VALID, 0);
    check_eq("t3_ovr", bus.OVERRUN, 0);

    // 4a: back-to-back A then B with READY low -> overrun, A kept.
    send_seq(6'b010101);
    send_seq(6'b001011);
    check_eq("t4_q_a", bus.Q, 4'hA);
    send_bit(1'b1);
    check_eq("t4_ovr", bus.OVERRUN, 1);
    check_eq("t4_q_kept", bus.Q, 4'hA);
    check_eq("t4_valid", bus.VALID, 1);
    send_bit(1'b1);
    check_eq("t4_ovr_pulse", bus.OVERRUN, 0);
    consume();
    check_eq("t4_drained", bus.VALID, 0);

    // 4b: READY high on B's delivery cycle -> replace, no overrun.
    send_seq(6'b010101);
    send_seq(6'b001011);
    bus.READY = 1'b1;
    send_bit(1'b1);
    bus.READY = 1'b0;
    check_eq("t4b_q_b", bus.Q, 4'h5);
    check_eq("t4b_valid", bus.VALID, 1);
    check_eq("t4b_no_ovr", bus.OVERRUN, 0);
    send_bit(1'b1);
    check_eq("t4b_no_ovr2", bus.OVERRUN, 0);
    consume();

    // 5: strobe every third cycle, glitches on idle cycles ignored.
    send_slow(1'b0);
    check_eq("t5_busy_start", bus.BUSY, 1);
    send_slow(1'b0);
    send_slow(1'b1);
    bus.ENB  = 1'b0;
    bus.S_IN = 1'b0;
    tick();
    check_eq("t5_busy_gap", bus.BUSY, 1);
    send_slow(1'b1);
    send_slow(1'b0);
    send_slow(1'b1);
    check_eq("t5_busy_end", bus.BUSY, 0);
    bus.ENB  = 1'b0;
    bus.S_IN = 1'b0;
    tick();
    check_eq("t5_valid", bus.VALID, 1);
    check_eq("t5_q", bus.Q, 4'h6);
    tick();
    check_eq("t5_idle_glitch", bus.BUSY, 0);
    bus.S_IN = 1'b1;
    consume();

    // 6: async reset mid-frame with a word pending.
    send_seq(6'b000111);
    send_bit(1'b1);
    check_eq("t6_pending", bus.VALID, 1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_q", bus.Q, 0);
    check_eq("t6_rst_valid", bus.VALID, 0);
    check_eq("t6_rst_busy", bus.BUSY, 0);
    check_eq("t6_rst_ferr", bus.FRAME_ERR, 0);
    check_eq("t6_rst_ovr", bus.OVERRUN, 0);
    @(negedge clk);
    rst_n = 1'b1;
    send_bit(1'b1);
    send_bit(1'b1);
    check_eq("t6_idle_busy", bus.BUSY, 0);
    check_eq("t6_idle_valid", bus.VALID, 0);
    send_seq(6'b010011);
    send_bit(1'b1);
    check_eq("t6_valid", bus.VALID, 1);
    check_eq("t6_q", bus.Q, 4'h9);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/receptor_serial.md
Name: receptor_serial

Overview:
- Serial-to-parallel framed receiver; the receive end of the team's 4-bit shift-register serial link.
- Samples one bit per ENB strobe from S_IN and detects a start bit.
- Assembles WIDTH data bits in MSB-first or LSB-first order, checks the stop bit, and presents the word on Q with a VALID/READY handshake.
- Sits between the serial line and the parallel consumer logic.

Parameters:
- WIDTH, 4, number of data bits per frame (>=2).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- RESET_N  input  1  asynchronous, active-low reset.
- ENB  input  1  bit strobe; S_IN is sampled only on clk edges where ENB=1.
- DIR  input  1  bit order: 0 = MSB first, 1 = LSB first. Captured at start bit.
- S_IN  input  1  serial line; idles high.
- READY  input  1  consumer accepts Q this cycle when VALID=1.
- Q  output  WIDTH  received word, registered.
- VALID  output  1  Q holds an unconsumed word.
- FRAME_ERR  output  1  one-cycle pulse; stop bit sampled as 0.
- OVERRUN  output  1  one-cycle pulse; good frame dropped because the holding register was full.
- BUSY  output  1  high while state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low (RESET_N).
- Reset values:
  - Q=0, VALID=0, FRAME_ERR=0, OVERRUN=0, BUSY=0.
  - state=IDLE, bit counter=0, shift register=0, captured DIR=0.
- RESET_N low mid-frame aborts the frame immediately. No output pulses are generated.
- ENB=0 cycles freeze state, counter and shift register. The handshake still operates.
- FSM states: IDLE, DATA, STOP. All transitions occur only on cycles with ENB=1.
  - IDLE:
    - S_IN=0 -> DATA; counter=0; capture DIR.
    - S_IN=1 -> stay in IDLE.
  - DATA:
    - Shift S_IN in.
    - MSB first: sh <= {sh[WIDTH-2:0], S_IN}.
    - LSB first: sh <= {S_IN, sh[WIDTH-1:1]}.
    - counter increments; when counter==WIDTH-1 on this strobe -> STOP.
  - STOP:
    - Always -> IDLE.
    - S_IN=1 -> deliver the word (see below).
    - S_IN=0 -> FRAME_ERR=1 for one cycle; word discarded. This 0 is NOT treated as a new start bit.
- Delivery on a good stop bit:
  - If VALID=0, or VALID=1 and READY=1 in the same cycle: Q <= sh and VALID=1 on the next cycle.
  - Otherwise: OVERRUN=1 for one cycle; Q and VALID unchanged; word dropped.
- Latency: VALID rises on the clk edge after the stop-bit strobe edge.
  - Minimum frame is WIDTH+2 strobes.
  - Back-to-back frames are allowed: the start bit may arrive on the strobe right after the stop bit.
- Handshake:
  - VALID=1 and READY=1 with no simultaneous delivery -> VALID=0 next cycle.
  - Simultaneous consume and delivery -> VALID stays 1 and Q takes the new word.
  - Q is stable while VALID=1 and READY=0.
- DIR changes mid-frame have no effect; the captured value is used until the frame ends.
- FRAME_ERR and OVERRUN are mutually exclusive and never sticky.

Decomposition:
- Shared include file (receptor_serial_defs):
  - state encoding constants: IDLE=2'b00, DATA=2'b01, STOP=2'b10.
  - bit-order constants: MSB_FIRST=0, LSB_FIRST=1.
- One natural sub-module, receptor_retencion: the WIDTH-bit output holding register with the VALID/READY logic and overrun detection.
- FSM, counter and shift register stay in the top module.

Test Plan (WIDTH=4, ENB=1 every cycle unless stated):
1. DIR=0; S_IN = 0,1,0,1,1,1 (start, data, stop); READY=0 -> VALID=1 one cycle after the stop sample, Q=4'b1011, FRAME_ERR=0. Q holds until READY=1, then VALID=0 next cycle.
2. DIR=1, same S_IN sequence -> Q=4'b1101. Flip DIR to 0 mid-frame -> Q still 4'b1101.
3. Stop bit 0: S_IN = 0,1,1,1,1,0, then 1 -> FRAME_ERR pulses exactly one cycle, VALID stays 0, BUSY=0 afterwards. The 0 stop bit does not start a new frame.
4. READY=0; frame A (4'hA) then frame B (4'h5) back-to-back -> Q=4'hA, VALID=1, OVERRUN pulses one cycle at B's stop. Repeat with READY=1 on B's stop-delivery cycle -> Q=4'h5, VALID stays 1, no OVERRUN.
5. ENB=1 only every 3rd cycle, frame 4'h6 MSB first -> Q=4'h6. S_IN glitches to 0 on ENB=0 cycles are ignored; BUSY is high from the start strobe through the stop strobe.
6. Assert RESET_N=0 asynchronously (between edges) after 2 data bits with VALID=1 pending -> all outputs 0 immediately. After release, S_IN=1 idle produces no activity; a fresh frame 4'h9 is received correctly.
